fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the PC, reads instruction memory combinationally
// and registers one instruction at a time toward decode, with redirect and range fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc8,
  output logic        fault,
  output logic [15:0] fetch_count
);

  localparam logic [32:0] PC_LIMIT    = 33'(MEM_WORDS) << 2;
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_fault;
  logic [15:0] r_count;

  logic        w_in_range;
  logic        w_load;
  logic        w_redirect;
  logic        w_drop;
  logic        w_fault_set;

  assign w_in_range = {1'b0, r_pc} < PC_LIMIT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  // Redirect outranks everything in RUN; FAULT only lets the held word drain.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_redirect  = 1'b0;
    w_drop      = 1'b0;
    w_fault_set = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = RUN;
      RUN: begin
        if (branch_taken) begin
          w_redirect = 1'b1;
        end else if (!w_in_range) begin
          w_state_nxt = FAULT;
          w_fault_set = 1'b1;
          w_drop      = r_valid && instr_ready;
        end else if (!r_valid || instr_ready) begin
          w_load = 1'b1;
        end
      end
      FAULT: w_drop = r_valid && instr_ready;
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc       <= RESET_PC_AL;
      r_valid    <= 1'b0;
      r_instr    <= 32'h0;
      r_instr_pc <= 32'h0;
      r_fault    <= 1'b0;
      r_count    <= 16'h0;
    end else begin
      if (w_load) begin
        r_instr    <= imem_rd;
        r_instr_pc <= r_pc;
        r_valid    <= 1'b1;
        r_pc       <= r_pc + 32'd4;
        r_count    <= r_count + 16'd1;
      end else if (w_redirect) begin
        r_pc    <= branch_target & 32'hFFFF_FFFC;
        r_valid <= 1'b0;
      end else if (w_drop) begin
        r_valid <= 1'b0;
      end
      if (w_fault_set) r_fault <= 1'b1;
    end
  end

  assign imem_addr   = r_pc & 32'hFFFF_FFFC;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_pc8   = r_instr_pc + 32'd8;
  assign fault       = r_fault;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table for the control corners, scoreboard for
// a random-backpressure stream, reset-in-flight checks and a fetch_count wrap run.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc8;
  logic        fault;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  assign imem_rd = (imem_addr < 32'h400) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_rd      (imem_rd),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_ready  (instr_ready),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_pc8    (instr_pc8),
    .fault        (fault),
    .fetch_count  (fetch_count)
  );

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        ef;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [16];

  logic [31:0] exp_q [$];
  logic        sb_on = 1'b0;
  int          n_pop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return mem[pc[9:2]];
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_pc"}, instr_pc, 32'h0);
    chk({tag, "_pc8"}, instr_pc8, 32'h8);
    chk({tag, "_fault"}, {31'b0, fault}, 32'h0);
    chk({tag, "_count"}, {16'b0, fetch_count}, 32'h0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Every accepted transfer is checked against the next address the bench expects.
  always @(negedge clk) begin
    if (sb_on && reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_empty: got pc %h expected nothing", instr_pc);
      end else begin
        logic [31:0] epc;
        epc = exp_q.pop_front();
        n_pop++;
        chk("sb_pc", instr_pc, epc);
        chk("sb_instr", instr, word_at(epc));
      end
    end
  end

  initial begin
    int exp_cnt;
    for (int i = 0; i < 256; i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[0] = 32'hE3A00005;

    tbl[0]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0,   1'b0, 16'd0};
    tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   32'h4,   1'b0, 16'd1};
    tbl[2]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h4,   1'b0, 16'd1};
    tbl[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h4,   1'b0, 16'd1};
    tbl[4]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h4,   1'b0, 16'd1};
    tbl[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   32'h8,   1'b0, 16'd2};
    tbl[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   32'hC,   1'b0, 16'd3};
    tbl[7]  = '{1'b1, 32'h43,  1'b0, 1'b0, 32'h8,   32'h40,  1'b0, 16'd3};
    tbl[8]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h40,  32'h44,  1'b0, 16'd4};
    tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h44,  32'h48,  1'b0, 16'd5};
    tbl[10] = '{1'b1, 32'h3FC, 1'b1, 1'b0, 32'h44,  32'h3FC, 1'b0, 16'd5};
    tbl[11] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h3FC, 32'h400, 1'b0, 16'd6};
    tbl[12] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h3FC, 32'h400, 1'b1, 16'd6};
    tbl[13] = '{1'b1, 32'h0,   1'b0, 1'b1, 32'h3FC, 32'h400, 1'b1, 16'd6};
    tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h3FC, 32'h400, 1'b1, 16'd6};
    tbl[15] = '{1'b1, 32'h8,   1'b1, 1'b0, 32'h3FC, 32'h400, 1'b1, 16'd6};

    reset = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    instr_ready = 1'b0;
    #2;
    chk_reset("por");

    // Vector table: boot, backpressure, redirect, end-of-memory fault.
    do_reset();
    for (int r = 0; r < 16; r++) begin
      branch_taken  = tbl[r].br;
      branch_target = tbl[r].tgt;
      instr_ready   = tbl[r].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_valid", r), {31'b0, instr_valid}, {31'b0, tbl[r].ev});
      chk($sformatf("row%0d_pc", r), instr_pc, tbl[r].epc);
      chk($sformatf("row%0d_pc8", r), instr_pc8, tbl[r].epc + 32'd8);
      chk($sformatf("row%0d_addr", r), imem_addr, tbl[r].eaddr);
      chk($sformatf("row%0d_fault", r), {31'b0, fault}, {31'b0, tbl[r].ef});
      chk($sformatf("row%0d_count", r), {16'b0, fetch_count}, {16'b0, tbl[r].ecnt});
      if (tbl[r].ev) chk($sformatf("row%0d_instr", r), instr, word_at(tbl[r].epc));
    end

    // Reset out of FAULT, then a clean restart from word 0.
    #2 reset = 1'b0;
    #1 chk_reset("fault_rst");
    branch_taken = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("restart_boot_valid", {31'b0, instr_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk("restart_valid", {31'b0, instr_valid}, 32'h1);
    chk("restart_instr", instr, 32'hE3A00005);
    chk("restart_pc", instr_pc, 32'h0);

    // Random backpressure stream checked by the scoreboard.
    do_reset();
    exp_q.delete();
    n_pop = 0;
    for (int i = 0; i < 200; i++) exp_q.push_back(32'(i) * 32'd4);
    sb_on = 1'b1;
    for (int c = 0; c < 200; c++) begin
      instr_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    instr_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    sb_on = 1'b0;
    chk("stream_held_valid", {31'b0, instr_valid}, 32'h1);
    chk("stream_accepts", 32'(n_pop), {16'b0, fetch_count} - 32'd1);

    // Asynchronous reset between edges while an instruction is held.
    #2 reset = 1'b0;
    #1 chk_reset("async_rst");

    // fetch_count wrap over ~65.5k loads, looping the PC with branches to 0.
    @(negedge clk);
    reset = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt = 0;
    while (exp_cnt < 65280) begin
      branch_taken = 1'b1;
      branch_target = 32'h0;
      @(posedge clk);
      #1;
      branch_taken = 1'b0;
      repeat (250) begin
        @(posedge clk);
        #1;
      end
      exp_cnt += 250;
      chk("wrap_period_cnt", {16'b0, fetch_count}, {16'b0, 16'(exp_cnt)});
      chk("wrap_period_pc", instr_pc, 32'd996);
    end
    branch_taken = 1'b1;
    branch_target = 32'h0;
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      exp_cnt++;
      chk("wrap_cnt", {16'b0, fetch_count}, {16'b0, 16'(exp_cnt)});
      chk("wrap_pc", instr_pc, 32'(i) * 32'd4);
      chk("wrap_instr", instr, word_at(32'(i) * 32'd4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
